// File: rtl/monitor_contador_if.sv
// Signal bundle between a contador under observation and its monitor.
// VALID has no ready partner: it is a qualifier that is high while EXP holds a checked prediction.
interface monitor_contador_if;
    logic       ENB;
    logic [1:0] MODO;
    logic [3:0] D;
    logic [3:0] Q;
    logic       RCO;
    logic       VALID;
    logic [3:0] EXP;
    logic [7:0] WRAPS;
    logic       ERR;
    logic [1:0] ERR_CODE;

    modport master (
        output ENB, MODO, D, Q, RCO,
        input  VALID, EXP, WRAPS, ERR, ERR_CODE
    );

    modport slave (
        input  ENB, MODO, D, Q, RCO,
        output VALID, EXP, WRAPS, ERR, ERR_CODE
    );
endinterface

// File: rtl/monitor_contador.sv
// Downstream checker for a 4-bit contador with one cycle of latency.
// It predicts Q/RCO from the previous edge's stimulus, counts wraps and latches the first fault.
module monitor_contador (
    input  logic               CLK,
    input  logic               RESET,
    monitor_contador_if.slave  mon,
    output logic [1:0]         state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       prev_enb_q, prev_enb_d;
    logic [1:0] prev_modo_q, prev_modo_d;
    logic [3:0] prev_d_q, prev_d_d;
    logic [3:0] prev_q_q, prev_q_d;
    logic       valid_q, valid_d;
    logic [3:0] exp_q, exp_d;
    logic [7:0] wraps_q, wraps_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;

    logic [3:0] exp_next;
    logic       rco_next;
    logic       q_bad;
    logic       rco_bad;

    // Prediction of what the contador shows at this edge, from last edge's inputs.
    always_comb begin
        exp_next = prev_q_q;
        rco_next = 1'b0;
        if (prev_enb_q) begin
            case (prev_modo_q)
                2'b00: begin
                    exp_next = prev_q_q + 4'd1;
                    rco_next = (prev_q_q == 4'hF);
                end
                2'b01: begin
                    exp_next = prev_q_q - 4'd1;
                    rco_next = (prev_q_q == 4'h0);
                end
                2'b10: begin
                    exp_next = prev_q_q - 4'd3;
                    rco_next = (prev_q_q < 4'd3);
                end
                default: begin
                    exp_next = prev_d_q;
                    rco_next = 1'b0;
                end
            endcase
        end
    end

    assign q_bad   = (mon.Q != exp_next);
    assign rco_bad = (mon.RCO != rco_next);

    always_comb begin
        state_d     = state_q;
        prev_enb_d  = prev_enb_q;
        prev_modo_d = prev_modo_q;
        prev_d_d    = prev_d_q;
        prev_q_d    = prev_q_q;
        valid_d     = valid_q;
        exp_d       = exp_q;
        wraps_d     = wraps_q;
        err_d       = err_q;
        err_code_d  = err_code_q;

        if (state_q != FAULT) begin
            prev_enb_d  = mon.ENB;
            prev_modo_d = mon.MODO;
            prev_d_d    = mon.D;
            prev_q_d    = mon.Q;
        end

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                state_d = TRACK;
            end
            TRACK: begin
                exp_d = exp_next;
                if (q_bad || rco_bad) begin
                    err_d      = 1'b1;
                    err_code_d = {rco_bad, q_bad};
                    valid_d    = 1'b0;
                    state_d    = FAULT;
                end else begin
                    valid_d = 1'b1;
                    // Saturate rather than wrap so a long run never looks short.
                    if (mon.RCO && (wraps_q != 8'hFF)) begin
                        wraps_d = wraps_q + 8'd1;
                    end
                end
            end
            FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            prev_enb_q  <= 1'b0;
            prev_modo_q <= 2'b00;
            prev_d_q    <= 4'h0;
            prev_q_q    <= 4'h0;
            valid_q     <= 1'b0;
            exp_q       <= 4'h0;
            wraps_q     <= 8'h00;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            prev_enb_q  <= prev_enb_d;
            prev_modo_q <= prev_modo_d;
            prev_d_q    <= prev_d_d;
            prev_q_q    <= prev_q_d;
            valid_q     <= valid_d;
            exp_q       <= exp_d;
            wraps_q     <= wraps_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign mon.VALID    = valid_q;
    assign mon.EXP      = exp_q;
    assign mon.WRAPS    = wraps_q;
    assign mon.ERR      = err_q;
    assign mon.ERR_CODE = err_code_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_monitor_contador.sv
// Bench for monitor_contador: an emulated contador feeds the monitor, with optional Q/RCO corruption.
// A reference model of the monitor is compared every cycle, plus hand-computed spot values.
module tb_monitor_contador;
    logic       CLK;
    logic       RESET;
    logic [1:0] state_dbg;

    monitor_contador_if bus ();

    monitor_contador dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .mon     (bus),
        .state_o (state_dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Emulated upstream contador (registered, one cycle of latency).
    logic [3:0] cnt_q   = 4'h0;
    logic       cnt_rco = 1'b0;

    task automatic drive(input bit rst, input bit enb, input logic [1:0] modo,
                         input logic [3:0] d, input bit fq_en, input logic [3:0] fq,
                         input bit fr_en, input bit fr);
        @(negedge CLK);
        RESET    = rst;
        bus.ENB  = enb;
        bus.MODO = modo;
        bus.D    = d;
        bus.Q    = fq_en ? fq : cnt_q;
        bus.RCO  = fr_en ? fr : cnt_rco;
        @(posedge CLK);
        if (rst) begin
            cnt_q   = 4'h0;
            cnt_rco = 1'b0;
        end else if (!enb) begin
            cnt_rco = 1'b0;
        end else begin
            case (modo)
                2'b00: begin cnt_rco = (cnt_q == 4'hF); cnt_q = cnt_q + 4'd1; end
                2'b01: begin cnt_rco = (cnt_q == 4'h0); cnt_q = cnt_q - 4'd1; end
                2'b10: begin cnt_rco = (cnt_q < 4'd3);  cnt_q = cnt_q - 4'd3; end
                default: begin cnt_rco = 1'b0; cnt_q = d; end
            endcase
        end
    endtask

    task automatic cyc(input bit enb, input logic [1:0] modo, input logic [3:0] d);
        drive(1'b0, enb, modo, d, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // Reference model: phase 0 idle, 1 tracking, 2 faulted.
    int         m_phase = 0;
    logic       m_valid = 1'b0;
    logic [3:0] m_exp   = 4'h0;
    int         m_wraps = 0;
    logic       m_err   = 1'b0;
    logic [1:0] m_code  = 2'b00;
    int         p_enb = 0, p_modo = 0, p_d = 0, p_q = 0;

    always @(posedge CLK) begin
        int  nxt;
        bit  rco_e, qbad, rbad;
        if (RESET) begin
            m_phase = 0; m_valid = 0; m_exp = 0; m_wraps = 0; m_err = 0; m_code = 0;
            p_enb = 0; p_modo = 0; p_d = 0; p_q = 0;
        end else if (m_phase != 2) begin
            if (m_phase == 1) begin
                if (p_enb == 0)       nxt = p_q;
                else if (p_modo == 0) nxt = p_q + 1;
                else if (p_modo == 1) nxt = p_q - 1;
                else if (p_modo == 2) nxt = p_q - 3;
                else                  nxt = p_d;
                rco_e = (p_enb != 0) && (p_modo != 3) && (nxt < 0 || nxt > 15);
                m_exp = 4'(nxt & 15);
                qbad  = (int'(bus.Q) != (nxt & 15));
                rbad  = (bus.RCO != rco_e);
                if (qbad || rbad) begin
                    m_err   = 1'b1;
                    m_code  = {rbad, qbad};
                    m_valid = 1'b0;
                    m_phase = 2;
                end else begin
                    m_valid = 1'b1;
                    if (bus.RCO && m_wraps < 255) m_wraps++;
                end
            end else begin
                m_valid = 1'b0;
                m_phase = 1;
            end
            p_enb = int'(bus.ENB); p_modo = int'(bus.MODO); p_d = int'(bus.D); p_q = int'(bus.Q);
        end
        #1;
        check("m_valid", int'(bus.VALID), int'(m_valid));
        check("m_exp", int'(bus.EXP), int'(m_exp));
        check("m_wraps", int'(bus.WRAPS), m_wraps);
        check("m_err", int'(bus.ERR), int'(m_err));
        check("m_code", int'(bus.ERR_CODE), int'(m_code));
        check("m_state", int'(state_dbg), m_phase);
    end

    typedef struct { bit enb; logic [1:0] modo; logic [3:0] d; } vec_t;
    vec_t mix[12];

    initial begin
        RESET = 1'b1; bus.ENB = 0; bus.MODO = 0; bus.D = 0; bus.Q = 0; bus.RCO = 0;
        mix[0]  = '{1, 2'd0, 4'd0};  mix[1]  = '{1, 2'd1, 4'd0};  mix[2]  = '{1, 2'd2, 4'd0};
        mix[3]  = '{0, 2'd3, 4'd7};  mix[4]  = '{1, 2'd3, 4'd7};  mix[5]  = '{1, 2'd1, 4'd0};
        mix[6]  = '{1, 2'd0, 4'd0};  mix[7]  = '{1, 2'd2, 4'd0};  mix[8]  = '{1, 2'd2, 4'd0};
        mix[9]  = '{0, 2'd1, 4'd0};  mix[10] = '{1, 2'd0, 4'd0};  mix[11] = '{1, 2'd3, 4'd15};

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("rst_valid", int'(bus.VALID), 0);
        check("rst_exp", int'(bus.EXP), 0);
        check("rst_wraps", int'(bus.WRAPS), 0);
        check("rst_err", int'(bus.ERR), 0);

        // Load 0, then a full up-count lap.
        cyc(1, 2'd3, 4'd0);
        repeat (16) cyc(1, 2'd0, 4'd0);
        cyc(0, 2'd0, 4'd0);
        #2;
        check("lap_exp", int'(bus.EXP), 0);
        check("lap_wraps", int'(bus.WRAPS), 1);
        check("lap_err", int'(bus.ERR), 0);
        check("lap_valid", int'(bus.VALID), 1);

        // Load 9 through mode 11.
        cyc(1, 2'd3, 4'd9);
        cyc(0, 2'd0, 4'd0);
        #2;
        check("load_exp", int'(bus.EXP), 9);
        check("load_err", int'(bus.ERR), 0);

        // From 1, subtract 3 -> E with carry.
        cyc(1, 2'd3, 4'd1);
        cyc(1, 2'd2, 4'd0);
        cyc(0, 2'd0, 4'd0);
        #2;
        check("sub3_exp", int'(bus.EXP), 14);
        check("sub3_wraps", int'(bus.WRAPS), 2);

        for (int i = 0; i < 12; i++) cyc(mix[i].enb, mix[i].modo, mix[i].d);

        // Q forced to 5 where 4 is due.
        cyc(1, 2'd3, 4'd3);
        cyc(1, 2'd0, 4'd0);
        drive(0, 1, 2'd0, 4'd0, 1, 4'd5, 0, 0);
        for (int i = 0; i < 20; i++) begin
            #2;
            check("qf_err", int'(bus.ERR), 1);
            check("qf_code", int'(bus.ERR_CODE), 1);
            check("qf_valid", int'(bus.VALID), 0);
            check("qf_exp", int'(bus.EXP), 4);
            drive(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1, 4'($urandom_range(0, 15)), 1, 1'($urandom_range(0, 1)));
        end

        // Spurious carry alone, then wrong Q and carry together.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 2'd3, 4'd2);
        cyc(1, 2'd0, 4'd0);
        drive(0, 1, 2'd0, 4'd0, 0, 4'd0, 1, 1);
        #2;
        check("rf_code", int'(bus.ERR_CODE), 2);
        check("rf_wraps", int'(bus.WRAPS), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 2'd3, 4'd2);
        cyc(1, 2'd0, 4'd0);
        drive(0, 1, 2'd0, 4'd0, 1, 4'd7, 1, 1);
        #2;
        check("both_code", int'(bus.ERR_CODE), 3);

        // 300 laps saturate the wrap count.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 2'd3, 4'd0);
        repeat (4801) cyc(1, 2'd0, 4'd0);
        #2;
        check("sat_wraps", int'(bus.WRAPS), 255);
        check("sat_err", int'(bus.ERR), 0);
        drive(0, 1, 2'd0, 4'd0, 1, cnt_q ^ 4'h8, 0, 0);
        cyc(1, 2'd0, 4'd0);
        #2;
        check("sat_fault_err", int'(bus.ERR), 1);
        check("sat_fault_wraps", int'(bus.WRAPS), 255);

        // Reset wins over FAULT and over a simultaneous mismatch.
        drive(1, 1, 2'd0, 4'd0, 1, 4'd9, 1, 1);
        #2;
        check("rr_valid", int'(bus.VALID), 0);
        check("rr_exp", int'(bus.EXP), 0);
        check("rr_wraps", int'(bus.WRAPS), 0);
        check("rr_err", int'(bus.ERR), 0);
        check("rr_code", int'(bus.ERR_CODE), 0);
        check("rr_state", int'(state_dbg), 0);
        cyc(1, 2'd3, 4'd5);
        #2;
        check("rr_idle_valid", int'(bus.VALID), 0);
        cyc(0, 2'd0, 4'd0);
        #2;
        check("rr_resume_valid", int'(bus.VALID), 1);
        check("rr_resume_exp", int'(bus.EXP), 5);
        cyc(0, 2'd0, 4'd0);

        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/monitor_contador.md
MONITOR_CONTADOR -- requirements
Module: monitor_contador

Interface
REQ-001 The block SHALL have the port CLK, an input, 1 bit wide, used as the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port RESET, an input, 1 bit wide, which is a synchronous, active-high reset.
REQ-003 The block SHALL have the port ENB, an input, 1 bit wide, carrying the counter enable that drives the upstream contador.
REQ-004 The block SHALL have the port MODO, an input, 2 bits wide, carrying the counter mode that drives the upstream contador.
REQ-005 The block SHALL have the port D, an input, 4 bits wide, carrying the counter load value that drives the upstream contador.
REQ-006 The block SHALL have the port Q, an input, 4 bits wide, carrying the registered output of the contador.
REQ-007 The block SHALL have the port RCO, an input, 1 bit wide, carrying the ripple-carry output of the contador.
REQ-008 The block SHALL have the port VALID, an output, 1 bit wide, asserted while the block tracks expected values.
REQ-009 The block SHALL have the port EXP, an output, 4 bits wide, giving the Q value predicted for the current cycle.
REQ-010 The block SHALL have the port WRAPS, an output, 8 bits wide, giving a saturating count of RCO pulses.
REQ-011 The block SHALL have the port ERR, an output, 1 bit wide, a sticky fault flag.
REQ-012 The block SHALL have the port ERR_CODE, an output, 2 bits wide, defined as: 01 Q mismatch, 10 RCO mismatch, 11 both.

Function
REQ-013 The block SHALL be a downstream checker that observes the contador and its stimulus; contador latency is one cycle, so Q and RCO sampled at edge n+1 reflect ENB, MODO and D sampled at edge n.
REQ-014 The block SHALL register the previous-edge values prev_enb, prev_modo, prev_d and prev_q on every edge in all states except FAULT.
REQ-015 The expected next Q SHALL be computed from the previous-edge values, mod 16, as follows:
- prev_enb=0 -> prev_q.
- MODO 00 -> prev_q+1.
- MODO 01 -> prev_q-1.
- MODO 10 -> prev_q-3.
- MODO 11 -> prev_d.
REQ-016 The expected RCO SHALL be 1 only when prev_enb=1 and one of the following holds; otherwise 0, including for MODO 11 and for ENB=0:
- MODO 00 with prev_q=F.
- MODO 01 with prev_q=0.
- MODO 10 with prev_q<3.
REQ-017 The block SHALL implement three states: IDLE, TRACK and FAULT.
REQ-018 In IDLE, the block SHALL capture the previous-edge values, hold VALID=0, and advance to TRACK on the next edge unconditionally.
REQ-019 In TRACK, on each edge the block SHALL drive EXP to the expected Q, set VALID=1, and compare the expected Q and RCO against the sampled Q and RCO.
REQ-020 On any mismatch in TRACK, the block SHALL load ERR_CODE per REQ-012, set ERR=1 and move to FAULT on that same edge, with the outputs visible after that edge.
REQ-021 In FAULT, the block SHALL freeze ERR, ERR_CODE, WRAPS, EXP and the previous-edge registers, hold VALID=0, and leave FAULT only on RESET.
REQ-022 In TRACK, WRAPS SHALL increment by 1 on each edge with sampled RCO=1, saturating at 255 with no wrap-around.
REQ-023 A sampled RCO=1 that is also a mismatch SHALL NOT increment WRAPS.
REQ-024 ENB=0 in TRACK SHALL still be checked: Q must hold its value and RCO must be 0.
REQ-025 Modes SHALL be allowed to change on any cycle, with each cycle checked against the mode sampled at the previous edge.

Reset
REQ-026 When RESET=1 at an edge, the block SHALL enter IDLE and drive VALID=0, EXP=0, WRAPS=0, ERR=0 and ERR_CODE=00, with the previous-edge registers cleared to 0.
REQ-027 RESET SHALL take priority over all state transitions, including exit from FAULT and the mismatch detected on the same edge.
REQ-028 After RESET deasserts, checking SHALL resume after one IDLE cycle, so the first compare occurs on the second edge.

Verification
REQ-029 The bench SHALL cover: reset, then Q=0 loaded, ENB=1, MODO=00 for 16 cycles -> Q runs 1..F,0; RCO once at 0; WRAPS=1; ERR=0.
REQ-030 The bench SHALL cover: TRACK with MODO=11, D=9 -> next Q=9, RCO=0, EXP=9, no error.
REQ-031 The bench SHALL cover: Q=1, MODO=10, ENB=1 -> expected Q=E, RCO=1; WRAPS increments.
REQ-032 The bench SHALL cover: forcing Q=5 when EXP=4 -> ERR=1 and ERR_CODE=01 after that edge, both held for 20 cycles, VALID=0.
REQ-033 The bench SHALL cover: forcing RCO=1 with Q=3 during an up-count -> ERR_CODE=10; forcing Q wrong with RCO wrong simultaneously -> ERR_CODE=11.
REQ-034 The bench SHALL cover: 300 up-count wraps -> WRAPS=255; then RESET for 1 cycle while in FAULT -> all outputs 0, IDLE; checking resumes on the second edge after reset.
